// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the 8-bit multi-cycle processor control path.
//   - opcode constants (instruction bits [7:5])
//   - seq_state_t : sequencer FSM state encoding
//   - ctrl_t      : per-instruction datapath control bundle
package cpu8_pkg;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_ADDI = 3'b100;
    localparam logic [2:0] OPC_SW   = 3'b101;
    localparam logic [2:0] OPC_LW   = 3'b110;
    localparam logic [2:0] OPC_SLL  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic alu_src;     // 0 = register operand, 1 = immediate
        logic alu_op;      // 0 = add, 1 = shift-left-logical
        logic mem_write;   // data access is a store
        logic mem_to_reg;  // writeback selects memory data
        logic reg_wr;      // instruction writes the register file
    } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// opcode_decode: purely combinational opcode -> control bundle translation.
// Ports:
//   opcode  in   OPC_W  latched instruction opcode
//   ctrl    out  ctrl_t datapath controls for this opcode (all 0 when illegal)
//   illegal out  1      opcode has no defined instruction
module opcode_decode
    import cpu8_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             illegal
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_ADD:  ctrl = '{alu_src: 1'b0, alu_op: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_wr: 1'b1};
            OPC_ADDI: ctrl = '{alu_src: 1'b1, alu_op: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_wr: 1'b1};
            OPC_SW:   ctrl = '{alu_src: 1'b1, alu_op: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0, reg_wr: 1'b0};
            OPC_LW:   ctrl = '{alu_src: 1'b1, alu_op: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b1, reg_wr: 1'b1};
            OPC_SLL:  ctrl = '{alu_src: 1'b1, alu_op: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b0, reg_wr: 1'b1};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit
// processor. Runs the instruction and data memory handshakes and drives
// phase-qualified datapath strobes. Traps (sticky) on an illegal opcode or
// when a memory ack does not arrive within MEM_TIMEOUT cycles.
// Optional build macro MULTICYCLE_SEQUENCER_RETIRE_CNT_EN adds retired_cnt.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   run                     keep issuing instructions while high
//   imem_req/imem_ack/instr instruction fetch handshake and data
//   dmem_req/dmem_ack       data access handshake (mem_write marks a store)
//   ir_load, pc_inc         one-cycle IR latch / PC increment pulses
//   reg_write               one-cycle register-file write pulse in WB
//   alu_src, alu_op         ALU operand / operation select, DECODE..WB
//   mem_to_reg              writeback mux select, DECODE..WB
//   busy, trap              activity and sticky fault status
//   retired_cnt             (macro only) instructions retired, wraps
module multicycle_sequencer
    import cpu8_pkg::*;
#(
    parameter int OPC_W       = 3,
    parameter int INSTR_W     = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] instr,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               reg_write,
    output logic               mem_write,
    output logic               alu_src,
    output logic               alu_op,
    output logic               mem_to_reg,
    output logic               busy,
    output logic               trap
`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
    ,
    output logic [15:0]        retired_cnt
`endif
);

    // Counter only needs to reach MEM_TIMEOUT-1; the terminal cycle traps.
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    seq_state_t       state_q, state_d;
    logic [OPC_W-1:0] opcode_q;
    ctrl_t            ctrl_q;
    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;
    logic             ack_now;
    logic             tmo_hit;

    opcode_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode  (opcode_q),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ack_now = (state_q == S_FETCH) ? imem_ack : dmem_ack;
    // An ack in the terminal cycle takes priority over the timeout.
    assign tmo_hit = (MEM_TIMEOUT != 0) && waiting && !ack_now && (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
                      else if (tmo_hit) state_d = S_TRAP;
            S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC:   state_d = (opcode_q == OPC_SW || opcode_q == OPC_LW) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_d = S_WB;
                      else if (tmo_hit) state_d = S_TRAP;
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic. Decoder output is used directly in DECODE and the
    // registered copy from EXEC onwards, so ALU selects are stable DECODE..WB.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 1'b0;
        mem_to_reg = 1'b0;
        busy       = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_DECODE: begin
                busy       = 1'b1;
                alu_src    = dec_ctrl.alu_src;
                alu_op     = dec_ctrl.alu_op;
                mem_to_reg = dec_ctrl.mem_to_reg;
            end
            S_EXEC, S_MEM, S_WB: begin
                busy       = 1'b1;
                alu_src    = ctrl_q.alu_src;
                alu_op     = ctrl_q.alu_op;
                mem_to_reg = ctrl_q.mem_to_reg;
                if (state_q == S_MEM) begin
                    dmem_req  = 1'b1;
                    mem_write = ctrl_q.mem_write;
                end
                if (state_q == S_WB) begin
                    pc_inc    = 1'b1;
                    reg_write = ctrl_q.reg_wr;
                end
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    // Opcode and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            ctrl_q   <= '0;
        end else begin
            if (state_q == S_FETCH && imem_ack) opcode_q <= instr[INSTR_W-1 -: OPC_W];
            if (state_q == S_DECODE)            ctrl_q   <= dec_ctrl;
        end
    end

    // Wait counter: counts unacked FETCH/MEM cycles, clears on ack or any
    // state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (MEM_TIMEOUT != 0 && waiting && !ack_now && state_d == state_q) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               retired_cnt <= '0;
        else if (state_q == S_WB) retired_cnt <= retired_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer. Output strobes are packed into
// one vector and compared per cycle against hand-computed values.
// Vector bit order: imem_req dmem_req ir_load pc_inc reg_write mem_write
//                   alu_src alu_op mem_to_reg busy trap
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       imem_req, imem_ack;
    logic [7:0] instr;
    logic       dmem_req, dmem_ack;
    logic       ir_load, pc_inc, reg_write, mem_write;
    logic       alu_src, alu_op, mem_to_reg, busy, trap;
`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Expected-vector constants (see bit order above).
    localparam logic [10:0] V_IDLE    = 11'h000;
    localparam logic [10:0] V_FETCH   = 11'h402;
    localparam logic [10:0] V_FETCHAK = 11'h502;
    localparam logic [10:0] V_ADD_X   = 11'h002;  // add DECODE/EXEC
    localparam logic [10:0] V_ADD_WB  = 11'h0C2;
    localparam logic [10:0] V_LW_X    = 11'h016;
    localparam logic [10:0] V_LW_MEM  = 11'h216;
    localparam logic [10:0] V_LW_WB   = 11'h0D6;
    localparam logic [10:0] V_SW_X    = 11'h012;
    localparam logic [10:0] V_SW_MEM  = 11'h232;
    localparam logic [10:0] V_SW_WB   = 11'h092;
    localparam logic [10:0] V_SLL_X   = 11'h01A;
    localparam logic [10:0] V_SLL_WB  = 11'h0DA;
    localparam logic [10:0] V_TRAP    = 11'h001;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .trap       (trap)
`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    wire [10:0] sig = {imem_req, dmem_req, ir_load, pc_inc, reg_write, mem_write,
                       alu_src, alu_op, mem_to_reg, busy, trap};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs shortly after the edge, check, advance.
    task automatic cyc(input string tag, input logic r, input logic iack,
                       input logic [7:0] ins, input logic dack, input logic [10:0] exp);
        run      = r;
        imem_ack = iack;
        instr    = ins;
        dmem_ack = dack;
        #2;
        check(tag, {21'd0, sig}, {21'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vec", {21'd0, sig}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // add: FETCH(ack) DECODE EXEC WB, then back to FETCH
        cyc("idle",       1, 0, 8'h00, 0, V_IDLE);
        cyc("add_fetch",  1, 1, 8'h00, 0, V_FETCHAK);
        cyc("add_dec",    1, 0, 8'h00, 0, V_ADD_X);
        cyc("add_exec",   1, 1, 8'hFF, 1, V_ADD_X);   // stray acks ignored
        cyc("add_wb",     1, 0, 8'h00, 0, V_ADD_WB);
        cyc("fetch_wait", 1, 0, 8'h00, 0, V_FETCH);

        // lw with three dmem wait cycles
        cyc("lw_fetch",   1, 1, 8'hC0, 0, V_FETCHAK);
        cyc("lw_dec",     1, 0, 8'h00, 0, V_LW_X);
        cyc("lw_exec",    1, 0, 8'h00, 0, V_LW_X);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1, 0, 8'h00, 0, V_LW_MEM);
        cyc("lw_mem_ack", 1, 0, 8'h00, 1, V_LW_MEM);
        cyc("lw_wb",      1, 0, 8'h00, 0, V_LW_WB);

        // sw with immediate ack; run drops in WB -> IDLE
        cyc("sw_fetch",   1, 1, 8'hA0, 0, V_FETCHAK);
        cyc("sw_dec",     1, 0, 8'h00, 0, V_SW_X);
        cyc("sw_exec",    1, 0, 8'h00, 0, V_SW_X);
        cyc("sw_mem",     1, 0, 8'h00, 1, V_SW_MEM);
        cyc("sw_wb",      0, 0, 8'h00, 0, V_SW_WB);
        cyc("sw_idle",    0, 0, 8'h00, 0, V_IDLE);

        // sll; run dropped mid-instruction still completes it
        cyc("sll_idle",   1, 0, 8'h00, 0, V_IDLE);
        cyc("sll_fetch",  1, 1, 8'hE5, 0, V_FETCHAK);
        cyc("sll_dec",    0, 0, 8'h00, 0, V_SLL_X);
        cyc("sll_exec",   0, 0, 8'h00, 0, V_SLL_X);
        cyc("sll_wb",     0, 0, 8'h00, 0, V_SLL_WB);
        cyc("sll_idle2",  0, 0, 8'h00, 0, V_IDLE);

        // illegal opcode 001 -> TRAP after DECODE, sticky
        cyc("ill_idle",   1, 0, 8'h00, 0, V_IDLE);
        cyc("ill_fetch",  1, 1, 8'h20, 0, V_FETCHAK);
        cyc("ill_dec",    1, 0, 8'h00, 0, V_ADD_X);
        for (int i = 0; i < 4; i++) cyc("ill_trap", 1, 1, 8'h00, 1, V_TRAP);

        // fetch timeout: 15 FETCH cycles with no ack, then TRAP
        do_reset();
        cyc("tmo_idle",   1, 0, 8'h00, 0, V_IDLE);
        for (int i = 0; i < 15; i++) cyc("tmo_fetch", 1, 0, 8'h00, 0, V_FETCH);
        cyc("tmo_trap",   1, 0, 8'h00, 0, V_TRAP);
        cyc("tmo_trap2",  1, 1, 8'h00, 0, V_TRAP);

        // ack on the terminal timeout cycle wins
        do_reset();
        cyc("ackw_idle",  1, 0, 8'h00, 0, V_IDLE);
        for (int i = 0; i < 14; i++) cyc("ackw_fetch", 1, 0, 8'h00, 0, V_FETCH);
        cyc("ackw_ack",   1, 1, 8'h00, 0, V_FETCHAK);
        cyc("ackw_dec",   1, 0, 8'h00, 0, V_ADD_X);

        // reset asserted mid-MEM drops everything immediately
        do_reset();
        cyc("rm_idle",    1, 0, 8'h00, 0, V_IDLE);
        cyc("rm_fetch",   1, 1, 8'hC0, 0, V_FETCHAK);
        cyc("rm_dec",     1, 0, 8'h00, 0, V_LW_X);
        cyc("rm_exec",    1, 0, 8'h00, 0, V_LW_X);
        #2;
        check("rm_in_mem", {21'd0, sig}, {21'd0, V_LW_MEM});
        rst_n = 1'b0;
        #1;
        check("rm_async", {21'd0, sig}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rm_after",   0, 0, 8'h00, 0, V_IDLE);
        cyc("rm_run",     1, 0, 8'h00, 0, V_IDLE);
        cyc("rm_fetch2",  1, 0, 8'h00, 0, V_FETCH);

`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
        do_reset();
        check("ret_reset", {16'd0, retired_cnt}, 32'd0);
        cyc("ret_idle", 1, 0, 8'h00, 0, V_IDLE);
        for (int i = 0; i < 3; i++) begin
            cyc("ret_fetch", 1, 1, 8'hE0, 0, V_FETCHAK);
            cyc("ret_dec",   1, 0, 8'h00, 0, V_SLL_X);
            cyc("ret_exec",  1, 0, 8'h00, 0, V_SLL_X);
            cyc("ret_wb",    1, 0, 8'h00, 0, V_SLL_WB);
        end
        check("ret_cnt3", {16'd0, retired_cnt}, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the 8-bit processor datapath one instruction at a time: fetch, decode, execute, memory and writeback.
- Drives the per-phase datapath strobes (PC increment, IR load, register write, memory write, ALU operand/op select, writeback mux).
- Runs handshakes with instruction and data memory.
- Sits between the memories and the register file/ALU; replaces the purely combinational opcode decode with phase-qualified control.

Parameters:
- OPC_W, 3, opcode width (instruction bits [7:5]).
- INSTR_W, 8, instruction width.
- MEM_TIMEOUT, 15, max cycles waiting on any ack before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; sequencer leaves IDLE and keeps issuing while high.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid on instr this cycle.
- instr  in  INSTR_W  fetched instruction.
- dmem_req  out  1  data memory access request (lw/sw).
- dmem_ack  in  1  data access complete.
- ir_load  out  1  one-cycle pulse: latch instr into IR.
- pc_inc  out  1  one-cycle pulse: PC += 1.
- reg_write  out  1  one-cycle pulse in WB.
- mem_write  out  1  qualifies dmem_req as a write (sw).
- alu_src  out  1  0 = register operand, 1 = immediate.
- alu_op  out  1  0 = add, 1 = shift-left-logical.
- mem_to_reg  out  1  writeback mux: 1 = memory data.
- busy  out  1  high in every state except IDLE and TRAP.
- trap  out  1  sticky: illegal opcode or memory timeout.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; IR opcode register 0; timeout counter 0. Takes effect immediately, mid-handshake included; requests drop the same instant.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: imem_req=1 until the imem_ack cycle. On ack, ir_load=1 the same cycle, opcode latched from instr[7:5], next state DECODE. imem_ack outside FETCH is ignored.
- DECODE (1 cycle):
  - opcodes 001, 010, 011 are illegal -> TRAP;
  - all others -> EXEC.
- EXEC (1 cycle): alu_src/alu_op valid; held stable from DECODE through WB. Next: MEM for 101/110, else WB.
- Decode table (alu_src, alu_op, mem_write, mem_to_reg, writes reg):
  - 000 add: 0, 0, 0, 0, yes.
  - 100 addi: 1, 0, 0, 0, yes.
  - 101 sw: 1, 0, 1, 0, no.
  - 110 lw: 1, 0, 0, 1, yes.
  - 111 sll: 1, 1, 0, 0, yes.
- MEM: dmem_req=1 with mem_write per table, held until dmem_ack. On the ack cycle, next state WB.
- WB (1 cycle):
  - pc_inc=1;
  - reg_write=1 if the opcode writes a register;
  - mem_to_reg held.
  - Next: FETCH if run=1, else IDLE.
- run sampled only in IDLE and WB. Dropping run mid-instruction completes the current instruction.
- Timeout: a counter increments each cycle in FETCH/MEM without ack and clears on ack or state change. Reaching MEM_TIMEOUT -> TRAP, request dropped.
- TRAP: trap=1, all strobes 0, busy=0. Exit only via reset.
- Latency: non-memory instruction = 4 cycles with single-cycle imem ack (FETCH, DECODE, EXEC, WB); lw/sw = 5 + dmem wait cycles.
- Simultaneous ack and timeout terminal count in the same cycle: ack wins.

Optional Feature:
- Macro: MULTICYCLE_SEQUENCER_RETIRE_CNT_EN.
- Defined:
  - adds output port retired_cnt [15:0];
  - increments once per WB cycle, wraps 16'hFFFF -> 0;
  - reset to 0 by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cpu8_pkg holds:
  - opcode constants OPC_ADD=3'b000, OPC_ADDI=3'b100, OPC_SW=3'b101, OPC_LW=3'b110, OPC_SLL=3'b111;
  - seq_state_t enum;
  - ctrl_t struct {alu_src, alu_op, mem_write, mem_to_reg, reg_wr}.
- Sub-module: opcode_decode, combinational opcode -> ctrl_t plus illegal flag, instanced once. The FSM registers its output in DECODE.

Test Plan:
- Reset, then run=1, instr=8'h00 (add), imem_ack in first FETCH cycle -> ir_load cycle 1, reg_write=1 and pc_inc=1 in cycle 4, alu_src=0, back in FETCH cycle 5.
- lw (8'hC0), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with mem_write=0; WB has reg_write=1, mem_to_reg=1.
- sw (8'hA0) -> dmem_req with mem_write=1; WB has reg_write=0, pc_inc=1.
- Illegal 8'h20 -> TRAP after DECODE, trap=1, busy=0, no reg_write/pc_inc; stays in TRAP until rst_n low.
- imem_ack withheld, MEM_TIMEOUT=15 -> imem_req dropped and trap=1 after 15 FETCH cycles.
- rst_n low mid-MEM -> dmem_req and all outputs 0 immediately; after release, IDLE. With the _EN macro defined, retired_cnt=0, and 3 sll instructions -> retired_cnt=3.
